// File: rtl/riscv_pkg.sv
// RV32I decode constants, immediate formats and the ID/EX bundle layout.
// Pure definitions; no logic, no latency.
// No handshake of its own; shared by the decode stage and its sub-blocks.
package riscv_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int RAW  = $clog2(NREG);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_fmt_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] rs1_val;
        logic [XLEN-1:0] rs2_val;
        logic [XLEN-1:0] imm;
        logic [RAW-1:0]  rd;
        logic            we;
    } id_bundle_t;
endpackage

// File: rtl/imm_gen.sv
// Immediate format select and sign-extended immediate from an instruction word.
// Purely combinational, zero latency.
// No handshake; follows whatever word the fetch side presents.
module imm_gen
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output imm_fmt_e        fmt,
    output logic [XLEN-1:0] imm
);
    always_comb begin
        case (instr[6:0])
            OP_JALR, OP_LOAD, OP_IMM: fmt = IMM_I;
            OP_STORE:                 fmt = IMM_S;
            OP_BRANCH:                fmt = IMM_B;
            OP_LUI, OP_AUIPC:         fmt = IMM_U;
            OP_JAL:                   fmt = IMM_J;
            default:                  fmt = IMM_NONE;
        endcase
    end

    always_comb begin
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end
endmodule

// File: rtl/id_stage.sv
// RV32I decode/operand-read stage: hazard resolution and registered ID/EX bundle.
// Latency 1 cycle accept->id_valid; EX/MEM bypass only when ID_FORWARD_EN is defined.
// if_ready drops on stall, flush, or a held bundle that EX has not taken.
module id_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_pc,
    input  logic [XLEN-1:0] if_instr,
    output logic [RAW-1:0]  rf_a1,
    output logic [RAW-1:0]  rf_a2,
    input  logic [XLEN-1:0] rf_rd1,
    input  logic [XLEN-1:0] rf_rd2,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic [RAW-1:0]  ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            mem_we,
    input  logic [RAW-1:0]  mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [RAW-1:0]  wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_instr,
    output logic [XLEN-1:0] id_rs1_val,
    output logic [XLEN-1:0] id_rs2_val,
    output logic [XLEN-1:0] id_imm,
    output logic [RAW-1:0]  id_rd,
    output logic            id_we
);
    logic [RAW-1:0]  rs1, rs2;
    imm_fmt_e        fmt;
    logic [XLEN-1:0] imm, rs1_val, rs2_val;
    logic            is_reg, rs1_used, rs2_used, writes, stall, accept;
    logic            wb_hit1, wb_hit2, ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    id_bundle_t      nxt, q;

    imm_gen u_imm_gen (.instr(if_instr), .fmt(fmt), .imm(imm));

    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];
    assign rf_a1  = rs1;
    assign rf_a2  = rs2;
    assign is_reg = (if_instr[6:0] == OP_REG);

    // Only LUI/AUIPC/JAL lack rs1; only branches, stores and R-type read rs2.
    assign rs1_used = (fmt == IMM_I) || (fmt == IMM_S) || (fmt == IMM_B) || is_reg;
    assign rs2_used = (fmt == IMM_S) || (fmt == IMM_B) || is_reg;
    assign writes   = (fmt == IMM_I) || (fmt == IMM_U) || (fmt == IMM_J) || is_reg;

    assign ex_hit1  = ex_we  && (ex_rd  != '0) && (ex_rd  == rs1);
    assign ex_hit2  = ex_we  && (ex_rd  != '0) && (ex_rd  == rs2);
    assign mem_hit1 = mem_we && (mem_rd != '0) && (mem_rd == rs1);
    assign mem_hit2 = mem_we && (mem_rd != '0) && (mem_rd == rs2);
    // Regfile writes on the same edge the read is sampled, so WB must always bypass.
    assign wb_hit1  = wb_we  && (wb_rd  != '0) && (wb_rd  == rs1);
    assign wb_hit2  = wb_we  && (wb_rd  != '0) && (wb_rd  == rs2);

`ifdef ID_FORWARD_EN
    assign stall = ex_is_load && ((rs1_used && ex_hit1) || (rs2_used && ex_hit2));
    assign rs1_val = (ex_hit1 && !ex_is_load) ? ex_data :
                     mem_hit1 ? mem_data : wb_hit1 ? wb_data : rf_rd1;
    assign rs2_val = (ex_hit2 && !ex_is_load) ? ex_data :
                     mem_hit2 ? mem_data : wb_hit2 ? wb_data : rf_rd2;
`else
    logic unused_fwd;
    assign unused_fwd = ^{ex_is_load, ex_data, mem_data};
    assign stall   = (rs1_used && (ex_hit1 || mem_hit1)) || (rs2_used && (ex_hit2 || mem_hit2));
    assign rs1_val = wb_hit1 ? wb_data : rf_rd1;
    assign rs2_val = wb_hit2 ? wb_data : rf_rd2;
`endif

    assign if_ready = !stall && !flush && (!id_valid || id_ready);
    assign accept   = if_valid && if_ready;

    always_comb begin
        nxt         = '0;
        nxt.pc      = if_pc;
        nxt.instr   = if_instr;
        nxt.rs1_val = rs1_val;
        nxt.rs2_val = rs2_val;
        nxt.imm     = imm;
        nxt.rd      = writes ? if_instr[11:7] : '0;
        nxt.we      = writes;
    end

    // Data only moves on accept, so a held bundle stays frozen under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            q        <= '0;
        end else if (flush) begin
            id_valid <= 1'b0;
        end else if (accept) begin
            id_valid <= 1'b1;
            q        <= nxt;
        end else if (id_ready) begin
            id_valid <= 1'b0;
        end
    end

    assign id_pc      = q.pc;
    assign id_instr   = q.instr;
    assign id_rs1_val = q.rs1_val;
    assign id_rs2_val = q.rs2_val;
    assign id_imm     = q.imm;
    assign id_rd      = q.rd;
    assign id_we      = q.we;
endmodule
